// File: rtl/lc3b_types.sv
// Shared LC-3b types: condition-code encoding, its reset value and the
// CC generator used by every CC-producing stage.
package lc3b_types;

  typedef logic [2:0] lc3b_nzp;

  localparam lc3b_nzp CC_RESET = 3'b010;

  // Exactly one of n/z/p comes out set; the caller supplies the sign bit
  // and a zero flag so the function stays width-independent.
  function automatic lc3b_nzp gencc(input logic sign, input logic zero);
    return {sign, zero, !sign && !zero};
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Saturating-counter direction table: writes are staged one cycle in a
// pending register, and reads of the pending index see the updated value.
module bht_2bit #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_req,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] ctr [ENTRIES];
  logic                pend_valid;
  logic [IDX_W-1:0]    pend_idx;
  logic                pend_taken;
  logic [CTR_BITS-1:0] pend_upd;
  logic [CTR_BITS-1:0] rd_val;

  function automatic logic [CTR_BITS-1:0] bump(input logic [CTR_BITS-1:0] v,
                                               input logic up);
    if (up) return (v == CTR_MAX) ? v : v + 1'b1;
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // Update is taken from the table at write time, so back-to-back trains of
  // one index chain through the stored value without extra forwarding.
  assign pend_upd = bump(ctr[pend_idx], pend_taken);
  assign rd_val   = (pend_valid && (pend_idx == rd_idx)) ? pend_upd : ctr[rd_idx];
  assign rd_taken = rd_val[CTR_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_taken <= 1'b0;
    end else begin
      pend_valid <= wr_req;
      pend_idx   <= wr_idx;
      pend_taken <= wr_taken;
      if (pend_valid) ctr[pend_idx] <= pend_upd;
    end
  end

endmodule

// File: rtl/ex_branch_predict_res.sv
// EX-stage branch resolver: CC register with MEM forwarding, taken/next-PC
// resolution, mispredict redirect, predictor training and statistics.
module ex_branch_predict_res
  import lc3b_types::*;
#(
  parameter int WIDTH       = 16,
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_BITS    = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_br,
  input  logic             ex_is_jump,
  input  logic [2:0]       ex_nzp,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  input  logic             fwd_valid,
  input  logic [WIDTH-1:0] fwd_res,
  input  logic             wb_cc_we,
  input  logic [WIDTH-1:0] wb_res,
  input  logic             clear_stats,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_addr,
  output logic             br_taken,
  output logic [2:0]       cc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  lc3b_nzp          cc_q;
  lc3b_nzp          eff_cc;
  logic             resolve;
  logic             taken;
  logic [WIDTH-1:0] next_pc;
  logic             unused_pred_taken;

  // The direction bit is implied by ex_pred_target, so only the target compare matters.
  assign unused_pred_taken = ex_pred_taken;

  assign eff_cc  = fwd_valid ? gencc(fwd_res[WIDTH-1], fwd_res == '0) : cc_q;
  assign resolve = ex_valid && !ex_stall && (ex_is_br || ex_is_jump);
  assign taken   = ex_is_jump || (ex_is_br && |(ex_nzp & eff_cc));
  assign next_pc = taken ? ex_target : ex_pc + WIDTH'(2);

  assign redirect      = resolve && (next_pc != ex_pred_target);
  assign redirect_addr = next_pc;
  assign br_taken      = taken;
  assign cc            = cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cc_q <= CC_RESET;
    else if (wb_cc_we) cc_q <= gencc(wb_res[WIDTH-1], wb_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (clear_stats) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (resolve && (br_count != '1)) br_count <= br_count + 1'b1;
      if (redirect && (mispred_count != '1)) mispred_count <= mispred_count + 1'b1;
    end
  end

  bht_2bit #(
    .ENTRIES  (BHT_ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[IDX_W:1]),
    .rd_taken (if_pred_taken),
    .wr_req   (resolve && ex_is_br),
    .wr_idx   (ex_pc[IDX_W:1]),
    .wr_taken (taken)
  );

endmodule
